// File: rtl/uctl_mem_reader.sv
// -----------------------------------------------------------------------------
// uctl_mem_reader
//
// Read-side initiator for the controller's single-port packet memory.
// Takes a start address and byte count, issues one byte read per cycle on the
// memory's ce/rw_en/addr interface (1-cycle registered read latency), and
// streams the returned bytes out on a valid/ready interface towards the USB
// TX packet path. The block never writes memory, so rw_en is tied to read.
//
// Handshake semantics (stream side): a byte transfers on a rising edge of
// coreClk where strm_valid & strm_ready are both 1. While strm_valid=1 and
// strm_ready=0, strm_data and strm_last are held stable. strm_valid never
// depends combinationally on strm_ready.
//
// Ports
//   coreClk, coreRst  : clock, asynchronous active-high reset
//   rd_start          : 1-cycle pulse, latches rd_startAddr / rd_byteCnt (IDLE only)
//   rd_startAddr      : first byte address
//   rd_byteCnt        : bytes to read (0 -> immediate rd_done, no memory access)
//   rd_abort          : terminate current transfer (READ / DRAIN), no rd_done
//   rd_busy           : transfer in progress (READ or DRAIN)
//   rd_done           : 1-cycle pulse on normal completion
//   mem_ce, mem_addr  : registered memory chip enable / address
//   rw_en             : memory read/write select, constant 1 (read)
//   mem_rdData        : memory read data, valid the cycle after ce is sampled
//   strm_data/valid/ready/last : output byte stream
//   dbg_state         : current FSM state (IDLE=0, READ=1, DRAIN=2, DONE=3)
// -----------------------------------------------------------------------------
module uctl_mem_reader #(
  parameter int MEM_ADDR_SIZE = 15,
  parameter int MEM_DATA_SIZE = 8,
  parameter int CNT_SIZE      = 11
) (
  input  logic                     coreClk,
  input  logic                     coreRst,
  input  logic                     rd_start,
  input  logic [MEM_ADDR_SIZE-1:0] rd_startAddr,
  input  logic [CNT_SIZE-1:0]      rd_byteCnt,
  input  logic                     rd_abort,
  output logic                     rd_busy,
  output logic                     rd_done,
  output logic                     mem_ce,
  output logic                     rw_en,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  input  logic [MEM_DATA_SIZE-1:0] mem_rdData,
  output logic [MEM_DATA_SIZE-1:0] strm_data,
  output logic                     strm_valid,
  input  logic                     strm_ready,
  output logic                     strm_last,
  output logic [1:0]               dbg_state
);

  localparam int FIFO_DEPTH = 4;
  localparam logic [MEM_ADDR_SIZE-1:0] ADDR_ONE = {{(MEM_ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_SIZE-1:0]      CNT_ONE  = {{(CNT_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;       // next address to issue
  logic [CNT_SIZE-1:0]      rem_q, rem_d;         // reads still to issue

  // Issue stage: registered memory request plus a tag marking the final byte.
  logic                     mem_ce_q;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_q;
  logic                     ce_last_q;

  // Return stage: memory sampled ce last edge, so mem_rdData is valid now.
  logic                     rv_q;
  logic                     rv_last_q;

  // 4-entry return FIFO; each entry carries its own last flag.
  logic [MEM_DATA_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic                     fifo_last_q [FIFO_DEPTH];
  logic [1:0]               wr_ptr_q, rd_ptr_q;
  logic [2:0]               fifo_cnt_q, fifo_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                     issue;        // register a read on this edge
  logic [MEM_ADDR_SIZE-1:0] issue_addr;
  logic                     issue_last;   // this read fetches the final byte
  logic                     flush;        // abort: drop FIFO and in-flight reads
  logic                     push;
  logic                     pop;
  logic                     head_last;
  logic [3:0]               occ_sum;
  logic                     credit_ok;

  assign push      = rv_q;
  assign pop       = strm_valid & strm_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  // Every read already issued or buffered owns a FIFO slot. A pop on this edge
  // frees one, which is what lets the stream run at one byte per cycle.
  assign occ_sum   = {1'b0, fifo_cnt_q}
                   + {3'b000, mem_ce_q}
                   + {3'b000, rv_q}
                   - {3'b000, pop};
  assign credit_ok = (occ_sum < 4'd4);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_addr = addr_q;
    issue_last = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort wins over a coincident start. The pipeline is empty in IDLE,
        // so the first read can be issued on the start edge itself.
        if (rd_start && !rd_abort) begin
          if (rd_byteCnt == '0) begin
            state_d = S_DONE;
          end else begin
            issue      = 1'b1;
            issue_addr = rd_startAddr;
            issue_last = (rd_byteCnt == CNT_ONE);
            addr_d     = rd_startAddr + ADDR_ONE;
            rem_d      = rd_byteCnt - CNT_ONE;
            state_d    = (rd_byteCnt == CNT_ONE) ? S_DRAIN : S_READ;
          end
        end
      end

      S_READ: begin
        if (rd_abort) begin
          flush   = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (credit_ok) begin
          // rem_q is at least 1 here: entering READ requires two or more bytes
          // and the final issue moves straight to DRAIN.
          issue      = 1'b1;
          issue_addr = addr_q;
          issue_last = (rem_q == CNT_ONE);
          addr_d     = addr_q + ADDR_ONE;   // wraps naturally at 2**MEM_ADDR_SIZE
          rem_d      = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (rd_abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (pop && head_last) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Single-cycle completion pulse; rd_start here is not looked at.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM, issue and return-pipe registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge coreClk or posedge coreRst) begin
    if (coreRst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_addr_q <= '0;
      ce_last_q  <= 1'b0;
      rv_q       <= 1'b0;
      rv_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      mem_ce_q  <= issue;
      ce_last_q <= issue & issue_last;
      if (issue) begin
        mem_addr_q <= issue_addr;
      end
      // The read registered last cycle returns data now; an abort discards it.
      rv_q      <= mem_ce_q & ~flush;
      rv_last_q <= ce_last_q & ~flush;
    end
  end

  // ---------------------------------------------------------------------------
  // Return FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge coreClk or posedge coreRst) begin
    if (coreRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rdData;
        fifo_last_q[wr_ptr_q] <= rv_last_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_ce     = mem_ce_q;
  assign mem_addr   = mem_addr_q;
  assign rw_en      = 1'b1;

  assign strm_valid = (fifo_cnt_q != 3'd0);
  assign strm_data  = fifo_data_q[rd_ptr_q];
  assign strm_last  = strm_valid & head_last;

  assign rd_busy    = (state_q == S_READ) || (state_q == S_DRAIN);
  assign rd_done    = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uctl_mem_reader.sv
// -----------------------------------------------------------------------------
// Testbench for uctl_mem_reader: a table of transfers driven one after another,
// a negedge monitor comparing issued addresses and streamed bytes against
// expected queues, and hand-written abort / reset sequences.
// -----------------------------------------------------------------------------
module tb_uctl_mem_reader;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int CW = 11;
  localparam int MEM_DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          coreClk;
  logic          coreRst;
  logic          rd_start;
  logic [AW-1:0] rd_startAddr;
  logic [CW-1:0] rd_byteCnt;
  logic          rd_abort;
  logic          rd_busy;
  logic          rd_done;
  logic          mem_ce;
  logic          rw_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdData = '0;
  logic [DW-1:0] strm_data;
  logic          strm_valid;
  logic          strm_ready;
  logic          strm_last;
  logic [1:0]    dbg_state;

  initial coreClk = 1'b0;
  always #5 coreClk = ~coreClk;

  uctl_mem_reader #(.MEM_ADDR_SIZE(AW), .MEM_DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
    .coreClk      (coreClk),
    .coreRst      (coreRst),
    .rd_start     (rd_start),
    .rd_startAddr (rd_startAddr),
    .rd_byteCnt   (rd_byteCnt),
    .rd_abort     (rd_abort),
    .rd_busy      (rd_busy),
    .rd_done      (rd_done),
    .mem_ce       (mem_ce),
    .rw_en        (rw_en),
    .mem_addr     (mem_addr),
    .mem_rdData   (mem_rdData),
    .strm_data    (strm_data),
    .strm_valid   (strm_valid),
    .strm_ready   (strm_ready),
    .strm_last    (strm_last),
    .dbg_state    (dbg_state)
  );

  // Memory model: registered read, one cycle after ce is sampled.
  logic [DW-1:0] mem [MEM_DEPTH];
  always @(posedge coreClk) begin
    if (mem_ce && rw_en) mem_rdData <= mem[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [DW:0]   exp_q[$];    // {last, data} in expected stream order
  logic [AW-1:0] addr_q[$];   // expected mem_addr sequence
  int n_checks;
  int n_fail;
  int issued_cnt;
  int acc_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last_hs;
  logic [DW:0]   e;
  logic [AW-1:0] ea;

  always @(negedge coreClk) begin
    if (coreRst) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_last_hs) begin
        check("done_after_last", 32'(rd_done), 32'd1);
        check("busy_low_at_done", 32'(rd_busy), 32'd0);
      end
      if (prev_stall) begin
        check("stall_valid_held", 32'(strm_valid), 32'd1);
        check("stall_data_stable", 32'(strm_data), 32'(prev_data));
      end
      if (mem_ce) begin
        issued_cnt++;
        if (addr_q.size() == 0) begin
          check("spurious_issue", 32'd1, 32'd0);
        end else begin
          ea = addr_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(ea));
        end
        check("outstanding_le4", 32'(issued_cnt - acc_cnt <= 4), 32'd1);
        check("rw_en", 32'(rw_en), 32'd1);
      end
      if (strm_valid && strm_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_byte", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strm_data_last", 32'({strm_last, strm_data}), 32'(e));
        end
      end
      prev_stall   = strm_valid && !strm_ready;
      prev_data    = strm_data;
      prev_last_hs = strm_valid && strm_ready && strm_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // mode: 0 = ready held 1, 1 = ready 0 for 10 cycles then toggling, 2 = random
  typedef struct {
    logic [AW-1:0] addr;
    int            cnt;
    int            mode;
    bit            mid_start;
    int            exp_done_cyc;   // cycle of rd_done after the start edge, -1 = unchecked
  } vec_t;

  vec_t vecs[7];

  task automatic push_expected(input logic [AW-1:0] addr, input int cnt);
    logic [AW-1:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = AW'(addr + AW'(i));
      addr_q.push_back(a);
      exp_q.push_back({(i == cnt - 1), mem[a]});
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc < 10) ? 1'b0 : 1'(cyc % 2);
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
  task automatic run_xfer(input vec_t v);
    int cyc;
    bit done_seen;
    issued_cnt = 0;
    acc_cnt    = 0;
    push_expected(v.addr, v.cnt);
    rd_startAddr = v.addr;
    rd_byteCnt   = CW'(v.cnt);
    rd_start     = 1'b1;
    strm_ready   = ready_for(v.mode, 0);
    @(posedge coreClk); #1;
    cyc = 0;
    done_seen = 0;
    while (!done_seen && cyc < 400) begin
      rd_start = 1'b0;
      if (rd_done) begin
        done_seen = 1;
        check("busy_at_done", 32'(rd_busy), 32'd0);
        if (v.exp_done_cyc >= 0) check("done_cycle", 32'(cyc), 32'(v.exp_done_cyc));
        if (v.cnt == 0) begin
          check("zero_no_ce", 32'(mem_ce), 32'd0);
          check("zero_no_valid", 32'(strm_valid), 32'd0);
        end
      end else begin
        if (v.mode == 0 && v.cnt > 0) begin
          if (cyc == 0) begin
            check("first_ce", 32'(mem_ce), 32'd1);
            check("first_addr", 32'(mem_addr), 32'(v.addr));
            check("busy_after_start", 32'(rd_busy), 32'd1);
          end
          if (cyc == 1) check("valid_not_yet", 32'(strm_valid), 32'd0);
          if (cyc == 2) check("first_valid", 32'(strm_valid), 32'd1);
        end
        if (v.mode == 1 && cyc == 10) check("issued_before_accept", 32'(issued_cnt), 32'd4);
        if (v.mid_start && cyc == 3) begin
          rd_start     = 1'b1;
          rd_startAddr = 15'h0200;
          rd_byteCnt   = 11'd5;
        end
        strm_ready = ready_for(v.mode, cyc + 1);
        @(posedge coreClk); #1;
        cyc++;
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    @(posedge coreClk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  waited;
    bit  done_any;
    n_checks = 0;
    n_fail   = 0;
    issued_cnt = 0;
    acc_cnt    = 0;
    coreRst      = 1'b1;
    rd_start     = 1'b0;
    rd_startAddr = '0;
    rd_byteCnt   = '0;
    rd_abort     = 1'b0;
    strm_ready   = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'((i * 7 + 3) ^ (i >> 7));
    mem[16'h0010] = 8'hA0;
    mem[16'h0011] = 8'hA1;
    mem[16'h0012] = 8'hA2;
    mem[16'h0013] = 8'hA3;

    vecs[0] = '{addr: 15'h0010, cnt: 4,  mode: 0, mid_start: 0, exp_done_cyc: 6};
    vecs[1] = '{addr: 15'h7FFE, cnt: 4,  mode: 0, mid_start: 0, exp_done_cyc: 6};
    vecs[2] = '{addr: 15'h0040, cnt: 16, mode: 1, mid_start: 0, exp_done_cyc: -1};
    vecs[3] = '{addr: 15'h0123, cnt: 0,  mode: 0, mid_start: 0, exp_done_cyc: 0};
    vecs[4] = '{addr: 15'h0300, cnt: 8,  mode: 0, mid_start: 1, exp_done_cyc: 10};
    vecs[5] = '{addr: 15'h7FF0, cnt: 20, mode: 2, mid_start: 0, exp_done_cyc: -1};
    vecs[6] = '{addr: 15'h0500, cnt: 1,  mode: 0, mid_start: 0, exp_done_cyc: 3};

    // Reset values
    #12;
    check("rst_busy", 32'(rd_busy), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_ce", 32'(mem_ce), 32'd0);
    check("rst_rw_en", 32'(rw_en), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(strm_valid), 32'd0);
    check("rst_last", 32'(strm_last), 32'd0);
    check("rst_data", 32'(strm_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge coreClk); #1;
    coreRst = 1'b0;
    repeat (2) @(posedge coreClk);
    #1;

    for (int k = 0; k < 7; k++) run_xfer(vecs[k]);

    // Abort after 5 accepted bytes, then a normal transfer must still work.
    issued_cnt = 0;
    acc_cnt    = 0;
    push_expected(15'h0800, 32);
    rd_startAddr = 15'h0800;
    rd_byteCnt   = 11'd32;
    rd_start     = 1'b1;
    strm_ready   = 1'b1;
    @(posedge coreClk); #1;
    rd_start = 1'b0;
    waited = 0;
    while (acc_cnt < 5 && waited < 100) begin
      @(posedge coreClk); #1;
      waited++;
    end
    check("abort_reach_5", 32'(acc_cnt >= 5), 32'd1);
    rd_abort = 1'b1;
    @(posedge coreClk); #1;
    rd_abort = 1'b0;
    check("abort_ce", 32'(mem_ce), 32'd0);
    check("abort_valid", 32'(strm_valid), 32'd0);
    check("abort_last", 32'(strm_last), 32'd0);
    check("abort_busy", 32'(rd_busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    addr_q.delete();
    done_any = 0;
    repeat (6) begin
      if (rd_done || strm_valid || mem_ce) done_any = 1;
      @(posedge coreClk); #1;
    end
    check("abort_quiet", 32'(done_any), 32'd0);
    run_xfer('{addr: 15'h0100, cnt: 2, mode: 0, mid_start: 0, exp_done_cyc: 4});

    // Asynchronous reset in the middle of a transfer.
    issued_cnt = 0;
    acc_cnt    = 0;
    push_expected(15'h0600, 16);
    rd_startAddr = 15'h0600;
    rd_byteCnt   = 11'd16;
    rd_start     = 1'b1;
    strm_ready   = 1'b1;
    @(posedge coreClk); #1;
    rd_start = 1'b0;
    repeat (3) @(posedge coreClk);
    #3;
    coreRst = 1'b1;
    #1;
    check("mrst_ce", 32'(mem_ce), 32'd0);
    check("mrst_rw_en", 32'(rw_en), 32'd1);
    check("mrst_busy", 32'(rd_busy), 32'd0);
    check("mrst_valid", 32'(strm_valid), 32'd0);
    check("mrst_last", 32'(strm_last), 32'd0);
    check("mrst_data", 32'(strm_data), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_done", 32'(rd_done), 32'd0);
    exp_q.delete();
    addr_q.delete();
    @(posedge coreClk); #1;
    coreRst = 1'b0;
    @(posedge coreClk); #1;
    run_xfer('{addr: 15'h0010, cnt: 4, mode: 0, mid_start: 0, exp_done_cyc: 6});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uctl_mem_reader.md
Name: uctl_mem_reader

Overview:
Read-side initiator for the controller's single-port packet memory. It accepts a start address and byte count from the endpoint/DMA logic. It then issues byte reads on the memory's ce/rw_en/addr interface, which has a 1-cycle registered read latency, and streams the returned bytes out on a valid/ready interface. The downstream consumer is the USB TX packet path. The block never writes memory.

Parameters:
MEM_ADDR_SIZE, 15, memory address width; addresses wrap modulo 2**MEM_ADDR_SIZE.
MEM_DATA_SIZE, 8, memory/stream data width.
CNT_SIZE, 11, byte-count width (max transfer 2**CNT_SIZE-1).

Ports:
coreClk  input  1  core clock; all logic on its rising edge.
coreRst  input  1  asynchronous, active-high reset.
rd_start  input  1  1-cycle pulse; latches rd_startAddr/rd_byteCnt; ignored while rd_busy=1.
rd_startAddr  input  MEM_ADDR_SIZE  first byte address.
rd_byteCnt  input  CNT_SIZE  number of bytes to read.
rd_abort  input  1  terminates the current transfer.
rd_busy  output  1  transfer in progress.
rd_done  output  1  1-cycle pulse on normal completion.
mem_ce  output  1  memory chip enable (registered).
rw_en  output  1  memory read/write select; 1 = read; held 1 at all times.
mem_addr  output  MEM_ADDR_SIZE  memory address (registered).
mem_rdData  input  MEM_DATA_SIZE  memory read data; valid the cycle after the memory samples ce=1.
strm_data  output  MEM_DATA_SIZE  stream byte.
strm_valid  output  1  strm_data valid.
strm_ready  input  1  consumer accepts; a byte transfers when strm_valid & strm_ready.
strm_last  output  1  qualifies the final byte of the transfer.

Behaviour:
- Reset values (asynchronous): rd_busy=0, rd_done=0, mem_ce=0, rw_en=1, mem_addr=0, strm_valid=0, strm_last=0, strm_data=0. FIFO is empty; counters are 0; FSM is in IDLE.
- FSM states:
  - IDLE: on rd_start with rd_byteCnt!=0, go to READ. On rd_start with rd_byteCnt==0, go to DONE and issue no memory access.
  - READ: issue reads until all bytes are issued, then go to DRAIN.
  - DRAIN: wait until the last byte is accepted, then go to DONE.
  - DONE: rd_done=1 for one cycle, then go to IDLE.
- rd_busy=1 in READ and DRAIN.
- Issue datapath:
  - Latched address and remaining-issue counter.
  - A read is issued by registering mem_ce=1 with mem_addr=current address for exactly one cycle per byte.
  - After each issue, address increments (wraps 2**MEM_ADDR_SIZE-1 -> 0) and remaining decrements.
  - mem_ce=0 whenever not issuing.
- Return capture: data returns 2 cycles after the issue decision: one edge to register ce, one edge for the memory. It is written into a 4-entry FIFO on the edge after mem_rdData becomes valid. A 2-deep pipe of valid flags tracks in-flight reads.
- Credit rule: issue allowed when FIFO occupancy + in-flight count - (pop this cycle) < 4. This guarantees no overflow and no lost data under any backpressure.
- Throughput: with strm_ready held 1, the block sustains one byte per cycle with no bubbles after the first byte.
- Latency: rd_start sampled at edge T0 -> mem_ce=1 after T0 -> first strm_valid=1 after T2.
- Stream output:
  - strm_data/strm_valid come from the FIFO head.
  - Data stays stable while strm_valid=1 and strm_ready=0.
  - Bytes are output in address order.
  - strm_last=1 with the byte whose accepted count equals rd_byteCnt.
- Completion: rd_done pulses the cycle after the last-byte handshake. rd_busy falls in that same cycle.
- rd_abort (in READ or DRAIN): on the next edge, stop issuing (mem_ce=0), flush the FIFO, and drop in-flight returns. strm_valid=0, strm_last=0, rd_busy=0, and the FSM returns to IDLE with no rd_done pulse. rd_abort in IDLE has no effect.
- Simultaneous events:
  - rd_abort has priority over rd_start.
  - rd_start in the DONE cycle is ignored.
  - A FIFO push and pop in the same cycle keeps occupancy unchanged.
- Reset mid-transfer: all state returns to reset values immediately; the returning memory byte is discarded.

Test Plan:
- Memory preloaded 0x10..0x13 = A0,A1,A2,A3; start addr 0x0010, cnt 4, strm_ready=1 -> mem_ce high 4 consecutive cycles with mem_addr 0x10,0x11,0x12,0x13. strm_data A0..A3 on consecutive cycles starting 2 cycles after start. strm_last on A3; rd_done 1 cycle later; rw_en stays 1.
- Wrap: addr 0x7FFE, cnt 4 -> mem_addr 7FFE,7FFF,0000,0001; data order matches.
- Backpressure: cnt 16, strm_ready=0 for 10 cycles after start, then toggling 1/0 -> at most 4 reads issued before the first accept. All 16 bytes arrive in order, none lost or duplicated, and strm_data stays stable while stalled.
- Zero count: start cnt 0 -> rd_done pulses the cycle after start; mem_ce never asserted; strm_valid never asserted.
- Abort: cnt 32, rd_abort after 5 accepts -> mem_ce=0 and strm_valid=0 next cycle; no rd_done. A new start at addr 0x0100, cnt 2 then completes normally with the correct bytes.
- Reset/start-while-busy: rd_start pulsed mid-transfer -> ignored, and the original transfer completes unchanged. coreRst asserted mid-transfer -> all outputs reach reset values asynchronously (mem_ce=0, rw_en=1, rd_busy=0).
